tl_width_downsizer: RTL

// TileLink-UL width converter between a wide inbound port (client side) and a narrower outbound port
// (manager side), e.g. a 256-bit L3/MMIO crossbar feeding a 64-bit peripheral bus.
// A channel: each wide data beat is split into narrow beats.
// D channel: narrow AccessAckData beats are merged back into wide beats.

---
 rtl/tl_width_downsizer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tl_width_downsizer.sv
// TileLink-UL width downsizer: splits wide A beats into narrow slices and
// merges narrow D AccessAckData beats back into wide beats.
module tl_width_downsizer #(
    parameter int IN_BYTES  = 32,
    parameter int OUT_BYTES = 8,
    parameter int ADDR_W    = 36,
    parameter int SOURCE_W  = 2,
    parameter int SIZE_W    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  auto_in_a_ready,
    input  logic                  auto_in_a_valid,
    input  logic [2:0]            auto_in_a_bits_opcode,
    input  logic [SIZE_W-1:0]     auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0]   auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]     auto_in_a_bits_address,
    input  logic [IN_BYTES-1:0]   auto_in_a_bits_mask,
    input  logic [8*IN_BYTES-1:0] auto_in_a_bits_data,
    input  logic                  auto_in_d_ready,
    output logic                  auto_in_d_valid,
    output logic [2:0]            auto_in_d_bits_opcode,
    output logic [SIZE_W-1:0]     auto_in_d_bits_size,
    output logic [SOURCE_W-1:0]   auto_in_d_bits_source,
    output logic                  auto_in_d_bits_denied,
    output logic [8*IN_BYTES-1:0] auto_in_d_bits_data,
    output logic                  auto_in_d_bits_corrupt,
    input  logic                  auto_out_a_ready,
    output logic                  auto_out_a_valid,
    output logic [2:0]            auto_out_a_bits_opcode,
    output logic [SIZE_W-1:0]     auto_out_a_bits_size,
    output logic [SOURCE_W-1:0]   auto_out_a_bits_source,
    output logic [ADDR_W-1:0]     auto_out_a_bits_address,
    output logic [OUT_BYTES-1:0]  auto_out_a_bits_mask,
    output logic [8*OUT_BYTES-1:0] auto_out_a_bits_data,
    output logic                  auto_out_d_ready,
    input  logic                  auto_out_d_valid,
    input  logic [2:0]            auto_out_d_bits_opcode,
    input  logic [SIZE_W-1:0]     auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0]   auto_out_d_bits_source,
    input  logic                  auto_out_d_bits_denied,
    input  logic [8*OUT_BYTES-1:0] auto_out_d_bits_data,
    input  logic                  auto_out_d_bits_corrupt
);

    localparam int R       = IN_BYTES / OUT_BYTES;
    localparam int LOG_IN  = $clog2(IN_BYTES);
    localparam int LOG_OUT = $clog2(OUT_BYTES);
    localparam int LW      = (R > 1) ? $clog2(R) : 1;
    localparam int OW      = 8 * OUT_BYTES;
    localparam int IW      = 8 * IN_BYTES;
    localparam int NSRC    = 1 << SOURCE_W;

    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    // Number of narrow slices per wide beat, minus one.
    function automatic logic [LW-1:0] nm1_of(input logic [SIZE_W-1:0] size);
        if (int'(size) >= LOG_IN) return LW'(R - 1);
        if (int'(size) <= LOG_OUT) return '0;
        return LW'((1 << (int'(size) - LOG_OUT)) - 1);
    endfunction

    function automatic logic [LW-1:0] lane0_of(input logic [SIZE_W-1:0] size,
                                               input logic [ADDR_W-1:0] addr);
        if (R == 1 || int'(size) >= LOG_IN) return '0;
        return LW'(addr >> LOG_OUT);
    endfunction

    logic [LW-1:0] a_idx_q, a_idx_d;
    logic [LW-1:0] a_l0, a_nm1, a_lane;
    logic          a_is_get, a_last, a_fire, a_full_mask;

    logic [LW-1:0] tbl_l0_q  [NSRC];
    logic [LW-1:0] tbl_nm1_q [NSRC];

    always_comb begin
        a_is_get    = (auto_in_a_bits_opcode == OP_GET);
        a_l0        = lane0_of(auto_in_a_bits_size, auto_in_a_bits_address);
        a_nm1       = a_is_get ? '0 : nm1_of(auto_in_a_bits_size);
        a_lane      = a_l0 + a_idx_q;
        a_last      = (a_idx_q == a_nm1);
        a_fire      = auto_in_a_valid && auto_out_a_ready;
        a_full_mask = a_is_get && (int'(auto_in_a_bits_size) >= LOG_OUT);
        a_idx_d     = a_idx_q;
        if (a_fire) begin
            a_idx_d = a_last ? '0 : a_idx_q + LW'(1);
        end
    end

    assign auto_out_a_valid        = auto_in_a_valid;
    assign auto_in_a_ready         = auto_out_a_ready && a_last;
    assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
    assign auto_out_a_bits_size    = auto_in_a_bits_size;
    assign auto_out_a_bits_source  = auto_in_a_bits_source;
    assign auto_out_a_bits_address = auto_in_a_bits_address;
    assign auto_out_a_bits_data    = auto_in_a_bits_data[a_lane*OW +: OW];
    assign auto_out_a_bits_mask    = a_full_mask ? '1
                                   : auto_in_a_bits_mask[a_lane*OUT_BYTES +: OUT_BYTES];

    // A split counter and per-source lane table, filled when a Get is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_idx_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                tbl_l0_q[i]  <= '0;
                tbl_nm1_q[i] <= '0;
            end
        end else begin
            a_idx_q <= a_idx_d;
            if (a_fire && a_last && a_is_get) begin
                tbl_l0_q[auto_in_a_bits_source]  <= a_l0;
                tbl_nm1_q[auto_in_a_bits_source] <= nm1_of(auto_in_a_bits_size);
            end
        end
    end

    if (R == 1) begin : g_pass
        assign auto_out_d_ready       = auto_in_d_ready;
        assign auto_in_d_valid        = auto_out_d_valid;
        assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
        assign auto_in_d_bits_size    = auto_out_d_bits_size;
        assign auto_in_d_bits_source  = auto_out_d_bits_source;
        assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
        assign auto_in_d_bits_data    = auto_out_d_bits_data;
        assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;
    end else begin : g_merge
        logic [IW-1:0]       buf_data_q, buf_data_d;
        logic [2:0]          buf_op_q, buf_op_d;
        logic [SIZE_W-1:0]   buf_size_q, buf_size_d;
        logic [SOURCE_W-1:0] buf_src_q, buf_src_d;
        logic                buf_den_q, buf_den_d;
        logic                buf_cor_q, buf_cor_d;
        logic                full_q, full_d;
        logic [LW-1:0]       d_cnt_q, d_cnt_d;
        logic [LW-1:0]       d_lane, d_nm1;
        logic                d_fire, d_release;

        always_comb begin
            d_fire     = auto_out_d_valid && (!full_q || auto_in_d_ready);
            d_release  = full_q && auto_in_d_ready;
            d_nm1      = tbl_nm1_q[auto_out_d_bits_source];
            d_lane     = tbl_l0_q[auto_out_d_bits_source] + d_cnt_q;
            buf_data_d = buf_data_q;
            buf_op_d   = buf_op_q;
            buf_size_d = buf_size_q;
            buf_src_d  = buf_src_q;
            buf_den_d  = buf_den_q;
            buf_cor_d  = buf_cor_q;
            d_cnt_d    = d_cnt_q;
            full_d     = full_q && !d_release;
            if (d_fire) begin
                buf_op_d   = auto_out_d_bits_opcode;
                buf_size_d = auto_out_d_bits_size;
                buf_src_d  = auto_out_d_bits_source;
                // First beat of a wide beat starts from a clean buffer.
                if (d_cnt_q == '0) begin
                    buf_data_d = '0;
                    buf_den_d  = auto_out_d_bits_denied;
                    buf_cor_d  = auto_out_d_bits_corrupt;
                end else begin
                    buf_den_d  = buf_den_q | auto_out_d_bits_denied;
                    buf_cor_d  = buf_cor_q | auto_out_d_bits_corrupt;
                end
                if (auto_out_d_bits_opcode == OP_ACK_DATA) begin
                    buf_data_d[d_lane*OW +: OW] = auto_out_d_bits_data;
                    if (d_cnt_q == d_nm1) begin
                        full_d  = 1'b1;
                        d_cnt_d = '0;
                    end else begin
                        d_cnt_d = d_cnt_q + LW'(1);
                    end
                end else begin
                    full_d  = 1'b1;
                    d_cnt_d = '0;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                full_q     <= 1'b0;
                d_cnt_q    <= '0;
                buf_data_q <= '0;
                buf_op_q   <= '0;
                buf_size_q <= '0;
                buf_src_q  <= '0;
                buf_den_q  <= 1'b0;
                buf_cor_q  <= 1'b0;
            end else begin
                full_q     <= full_d;
                d_cnt_q    <= d_cnt_d;
                buf_data_q <= buf_data_d;
                buf_op_q   <= buf_op_d;
                buf_size_q <= buf_size_d;
                buf_src_q  <= buf_src_d;
                buf_den_q  <= buf_den_d;
                buf_cor_q  <= buf_cor_d;
            end
        end

        assign auto_out_d_ready       = !full_q || auto_in_d_ready;
        assign auto_in_d_valid        = full_q;
        assign auto_in_d_bits_opcode  = buf_op_q;
        assign auto_in_d_bits_size    = buf_size_q;
        assign auto_in_d_bits_source  = buf_src_q;
        assign auto_in_d_bits_denied  = buf_den_q;
        assign auto_in_d_bits_data    = buf_data_q;
        assign auto_in_d_bits_corrupt = buf_cor_q;
    end

endmodule
